// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK SPI poller.
package jstk_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE} state_t;

  localparam int          JSTK_BYTES   = 5;
  localparam logic [10:0] JSTK_CENTRE  = 11'd512;
  localparam logic [5:0]  JSTK_CMD_HDR = 6'b100000;

endpackage

// File: rtl/spi_byte_shift.sv
// One 8-bit SPI mode-0 transfer: MSB first, miso sampled on the rising sclk edge.
module spi_byte_shift #(
  parameter int SCLK_HALF = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       done
);

  localparam int HW = $clog2(SCLK_HALF + 1);

  logic [HW-1:0] half_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh;
  logic          active;

  // mosi only moves on the start cycle or together with a falling sclk edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      active   <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      rx_byte  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active   <= 1'b1;
        half_cnt <= '0;
        bit_cnt  <= '0;
        sclk     <= 1'b0;
        tx_sh    <= tx_byte;
        mosi     <= tx_byte[7];
      end else if (active) begin
        if (half_cnt == HW'(SCLK_HALF - 1)) begin
          half_cnt <= '0;
          sclk     <= ~sclk;
          if (!sclk) begin
            rx_byte <= {rx_byte[6:0], miso};
          end else if (bit_cnt == 3'd7) begin
            active <= 1'b0;
            done   <= 1'b1;
            mosi   <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx_sh   <= {tx_sh[6:0], 1'b0};
            mosi    <= tx_sh[6];
          end
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jstk_spi_reader.sv
// Polls a PmodJSTK joystick every POLL_CYC cycles and publishes X/Y/buttons
// atomically once each 5-byte frame has been fully received.
module jstk_spi_reader
  import jstk_pkg::*;
#(
  parameter int SCLK_HALF = 50,
  parameter int CS_SETUP  = 1500,
  parameter int BYTE_GAP  = 1000,
  parameter int POLL_CYC  = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  led,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic [10:0] x_val,
  output logic [10:0] y_val,
  output logic [2:0]  btn,
  output logic        valid,
  output logic        busy
);

  localparam int PW       = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam int WAIT_MAX = (CS_SETUP > BYTE_GAP) ? CS_SETUP : BYTE_GAP;
  localparam int WW       = $clog2(WAIT_MAX + 1);

  state_t        state;
  logic [PW-1:0] poll_cnt;
  logic [WW-1:0] wait_cnt;
  logic [2:0]    byte_idx;
  logic [7:0]    cmd_byte;
  logic [7:0]    slot [0:JSTK_BYTES-2];
  logic          start;
  logic [7:0]    tx_byte;
  logic [7:0]    rx_byte;
  logic          byte_done;

  // The poll counter never stops, so frame starts stay exactly POLL_CYC apart
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      poll_cnt <= '0;
    end else if (poll_cnt == PW'(POLL_CYC - 1)) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  always_comb begin
    start   = 1'b0;
    tx_byte = 8'h00;
    if (state == SETUP) begin
      tx_byte = cmd_byte;
      start   = (wait_cnt == WW'(CS_SETUP - 1));
    end else if (state == GAP) begin
      start = (wait_cnt == WW'(BYTE_GAP - 1));
    end
  end

  spi_byte_shift #(
    .SCLK_HALF(SCLK_HALF)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .tx_byte(tx_byte),
    .miso   (miso),
    .sclk   (sclk),
    .mosi   (mosi),
    .rx_byte(rx_byte),
    .done   (byte_done)
  );

  // The last byte goes straight into the outputs, so nothing partial is ever visible
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      byte_idx <= '0;
      cmd_byte <= '0;
      for (int i = 0; i < JSTK_BYTES - 1; i++) slot[i] <= '0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      valid    <= 1'b0;
      x_val    <= JSTK_CENTRE;
      y_val    <= JSTK_CENTRE;
      btn      <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (poll_cnt == PW'(POLL_CYC - 1)) begin
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            cmd_byte <= {JSTK_CMD_HDR, led};
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (start) begin
            byte_idx <= '0;
            state    <= SHIFT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (byte_done) begin
            if (byte_idx < 3'(JSTK_BYTES - 1)) begin
              slot[byte_idx[1:0]] <= rx_byte;
              wait_cnt            <= '0;
              state               <= GAP;
            end else begin
              x_val <= {1'b0, slot[1][1:0], slot[0]};
              y_val <= {1'b0, slot[3][1:0], slot[2]};
              btn   <= rx_byte[2:0];
              valid <= 1'b1;
              cs_n  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        GAP: begin
          if (start) begin
            byte_idx <= byte_idx + 3'd1;
            state    <= SHIFT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Bench for jstk_spi_reader: a joystick slave model plus an arithmetic reference
// for how the received bytes map onto x_val/y_val/btn.
module tb_jstk_spi_reader;

  localparam int SCLK_HALF = 4;
  localparam int CS_SETUP  = 20;
  localparam int BYTE_GAP  = 12;
  localparam int POLL_CYC  = 800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  led = 2'b00;
  logic        miso = 1'b0;
  logic        sclk, mosi, cs_n, valid, busy;
  logic [10:0] x_val, y_val;
  logic [2:0]  btn;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  jstk_spi_reader #(
    .SCLK_HALF(SCLK_HALF),
    .CS_SETUP (CS_SETUP),
    .BYTE_GAP (BYTE_GAP),
    .POLL_CYC (POLL_CYC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .led  (led),
    .miso (miso),
    .sclk (sclk),
    .mosi (mosi),
    .cs_n (cs_n),
    .x_val(x_val),
    .y_val(y_val),
    .btn  (btn),
    .valid(valid),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Joystick slave: presents resp[] MSB first, shifts on sclk fall, records mosi on rise
  logic [7:0] resp [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] seen_mosi [5];
  int         rises_in_frame = 0;
  int         bit_pos = 0;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;

  always @(cs_n, sclk) begin
    if (cs_n === 1'b0 && prev_cs === 1'b1) begin
      bit_pos = 0;
      rises_in_frame = 0;
      for (int k = 0; k < 5; k++) seen_mosi[k] = 8'h00;
      miso = resp[0][7];
    end else if (cs_n === 1'b0 && prev_sclk === 1'b1 && sclk === 1'b0) begin
      bit_pos++;
      if (bit_pos < 40) miso = resp[bit_pos / 8][7 - bit_pos % 8];
    end else if (cs_n === 1'b0 && prev_sclk === 1'b0 && sclk === 1'b1) begin
      if (rises_in_frame < 40) seen_mosi[rises_in_frame / 8][7 - rises_in_frame % 8] = mosi;
      rises_in_frame++;
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

  // Mid-cycle monitor: valid pulse count and mosi must not move across or during sclk high
  int   valid_total = 0;
  int   mosi_bad = 0;
  logic s_sclk = 1'b0;
  logic s_mosi = 1'b0;
  always @(negedge clk) begin
    if (valid === 1'b1) valid_total++;
    if (sclk === 1'b1 && mosi !== s_mosi) mosi_bad++;
    s_sclk = sclk;
    s_mosi = mosi;
  end

  function automatic int model_pos(input logic [7:0] lo, input logic [7:0] hi);
    return int'(lo) + 256 * (int'(hi) % 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int   f_fall_cyc = 0, f_prev_fall = 0, f_first_rise, f_rises, f_bad_period;
  int   f_gap_min, f_gap_max, f_valid_pulses, f_hold_bad;
  bit   f_timeout;
  logic f_valid_at_end, f_valid_after;

  // Follows one whole frame cycle by cycle; the test tasks judge the results
  task automatic capture_frame(input bit change_led, input logic [1:0] new_led);
    int n, last_rise, last_fall, gap, v0;
    logic p_sclk;
    logic [10:0] hx, hy;
    logic [2:0] hb;
    f_timeout = 0; f_rises = 0; f_bad_period = 0; f_hold_bad = 0;
    f_gap_min = 1 << 30; f_gap_max = -1; f_first_rise = -1;
    last_rise = 0; last_fall = 0;
    n = 0;
    while (cs_n !== 1'b0 && n < POLL_CYC + 50) begin tick(); n++; end
    if (cs_n !== 1'b0) begin f_timeout = 1; return; end
    f_prev_fall = f_fall_cyc;
    f_fall_cyc  = cyc;
    hx = x_val; hy = y_val; hb = btn; v0 = valid_total; p_sclk = sclk;
    n = 0;
    while (cs_n === 1'b0 && n < POLL_CYC) begin
      tick(); n++;
      if (cs_n === 1'b0 && (x_val !== hx || y_val !== hy || btn !== hb)) f_hold_bad++;
      if (!p_sclk && sclk) begin
        f_rises++;
        if (f_rises == 1) begin
          f_first_rise = cyc - f_fall_cyc;
          if (change_led) led = new_led;
        end else if (f_rises % 8 == 1) begin
          gap = cyc - last_fall;
          if (gap < f_gap_min) f_gap_min = gap;
          if (gap > f_gap_max) f_gap_max = gap;
        end else if (cyc - last_rise != 2 * SCLK_HALF) begin
          f_bad_period++;
        end
        last_rise = cyc;
      end
      if (p_sclk && !sclk) last_fall = cyc;
      p_sclk = sclk;
    end
    if (cs_n !== 1'b1) f_timeout = 1;
    f_valid_at_end = valid;
    tick();
    f_valid_after  = valid;
    f_valid_pulses = valid_total - v0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    led = 2'b10;
    repeat (5) tick();
    checks++; if (cs_n !== 1'b1) begin fails++; $display("[TB] FAIL reset_cs_n: got %b, expected 1", cs_n); end
    checks++; if (sclk !== 1'b0) begin fails++; $display("[TB] FAIL reset_sclk: got %b, expected 0", sclk); end
    checks++; if (mosi !== 1'b0) begin fails++; $display("[TB] FAIL reset_mosi: got %b, expected 0", mosi); end
    checks++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b, expected 0", valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (x_val !== 11'd512) begin fails++; $display("[TB] FAIL reset_x: got %0d, expected 512", x_val); end
    checks++; if (y_val !== 11'd512) begin fails++; $display("[TB] FAIL reset_y: got %0d, expected 512", y_val); end
    checks++; if (btn !== 3'd0) begin fails++; $display("[TB] FAIL reset_btn: got %0d, expected 0", btn); end
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (cs_n !== 1'b0 && n < POLL_CYC + 50) begin tick(); n++; end
    checks++; if (n != POLL_CYC) begin fails++; $display("[TB] FAIL first_frame_delay: got %0d, expected %0d", n, POLL_CYC); end
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL busy_at_start: got %b, expected 1", busy); end
    n = 0;
    while (cs_n === 1'b0 && n < POLL_CYC) begin tick(); n++; end
  endtask

  task automatic test_spec_frame();
    resp = '{8'h34, 8'h02, 8'hFF, 8'h03, 8'h05};
    led  = 2'b10;
    capture_frame(1'b0, 2'b00);
    checks++; if (f_timeout) begin fails++; $display("[TB] FAIL spec_timeout: got timeout, expected a full frame"); end
    checks++; if (f_first_rise != CS_SETUP + SCLK_HALF) begin fails++; $display("[TB] FAIL spec_setup: got %0d, expected %0d", f_first_rise, CS_SETUP + SCLK_HALF); end
    checks++; if (rises_in_frame != 40) begin fails++; $display("[TB] FAIL spec_bits: got %0d, expected 40", rises_in_frame); end
    checks++; if (f_bad_period != 0) begin fails++; $display("[TB] FAIL spec_bit_period: got %0d bad periods, expected 0", f_bad_period); end
    // one extra cycle per gap: the frame FSM takes a cycle to accept each finished byte
    checks++; if (f_gap_min != BYTE_GAP + SCLK_HALF + 1 || f_gap_max != BYTE_GAP + SCLK_HALF + 1) begin
      fails++; $display("[TB] FAIL spec_gap: got %0d..%0d, expected %0d", f_gap_min, f_gap_max, BYTE_GAP + SCLK_HALF + 1);
    end
    checks++; if (f_valid_pulses != 1) begin fails++; $display("[TB] FAIL spec_valid_count: got %0d, expected 1", f_valid_pulses); end
    checks++; if (f_valid_at_end !== 1'b1 || f_valid_after !== 1'b0) begin fails++; $display("[TB] FAIL spec_valid_shape: got %b%b, expected 10", f_valid_at_end, f_valid_after); end
    checks++; if (x_val !== 11'd564) begin fails++; $display("[TB] FAIL spec_x: got %0d, expected 564", x_val); end
    checks++; if (y_val !== 11'd1023) begin fails++; $display("[TB] FAIL spec_y: got %0d, expected 1023", y_val); end
    checks++; if (btn !== 3'b101) begin fails++; $display("[TB] FAIL spec_btn: got %b, expected 101", btn); end
    checks++; if (f_hold_bad != 0) begin fails++; $display("[TB] FAIL spec_hold: got %0d early changes, expected 0", f_hold_bad); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL spec_busy_end: got %b, expected 0", busy); end
    checks++; if (seen_mosi[0] !== 8'h82) begin fails++; $display("[TB] FAIL spec_mosi0: got %h, expected 82", seen_mosi[0]); end
    for (int k = 1; k < 5; k++) begin
      checks++; if (seen_mosi[k] !== 8'h00) begin fails++; $display("[TB] FAIL spec_mosi%0d: got %h, expected 00", k, seen_mosi[k]); end
    end
    checks++; if (mosi_bad != 0) begin fails++; $display("[TB] FAIL spec_mosi_stable: got %0d violations, expected 0", mosi_bad); end
  endtask

  task automatic test_reset_mid_frame();
    int n, v0, c_rel;
    for (int k = 0; k < 5; k++) resp[k] = 8'($urandom_range(0, 255));
    n = 0;
    while (cs_n !== 1'b0 && n < POLL_CYC + 50) begin tick(); n++; end
    n = 0;
    while (rises_in_frame < 17 && n < 2000) begin tick(); n++; end
    checks++; if (rises_in_frame < 17) begin fails++; $display("[TB] FAIL abort_reach_byte2: got %0d rises, expected 17", rises_in_frame); end
    v0 = valid_total;
    #3 rst = 1'b0;
    #1;
    checks++; if (cs_n !== 1'b1) begin fails++; $display("[TB] FAIL abort_cs_n: got %b, expected 1", cs_n); end
    checks++; if (sclk !== 1'b0) begin fails++; $display("[TB] FAIL abort_sclk: got %b, expected 0", sclk); end
    checks++; if (x_val !== 11'd512 || y_val !== 11'd512) begin fails++; $display("[TB] FAIL abort_centre: got %0d/%0d, expected 512/512", x_val, y_val); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy: got %b, expected 0", busy); end
    repeat (3) tick();
    checks++; if (valid_total != v0) begin fails++; $display("[TB] FAIL abort_no_valid: got %0d pulses, expected 0", valid_total - v0); end
    @(negedge clk);
    c_rel = cyc;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) resp[k] = 8'($urandom_range(0, 255));
    capture_frame(1'b0, 2'b00);
    checks++; if (f_timeout) begin fails++; $display("[TB] FAIL recover_timeout: got timeout, expected a full frame"); end
    checks++; if (f_fall_cyc - c_rel != POLL_CYC) begin fails++; $display("[TB] FAIL recover_delay: got %0d, expected %0d", f_fall_cyc - c_rel, POLL_CYC); end
    checks++; if (f_valid_pulses != 1) begin fails++; $display("[TB] FAIL recover_valid: got %0d, expected 1", f_valid_pulses); end
    checks++; if (x_val !== 11'(model_pos(resp[0], resp[1]))) begin fails++; $display("[TB] FAIL recover_x: got %0d, expected %0d", x_val, model_pos(resp[0], resp[1])); end
    checks++; if (y_val !== 11'(model_pos(resp[2], resp[3]))) begin fails++; $display("[TB] FAIL recover_y: got %0d, expected %0d", y_val, model_pos(resp[2], resp[3])); end
  endtask

  task automatic test_random_frames();
    logic [1:0] led_start, new_led;
    led_start = 2'($urandom_range(0, 3));
    led = led_start;
    for (int i = 0; i < 4; i++) begin
      new_led = ~led_start;
      for (int k = 0; k < 5; k++) resp[k] = 8'($urandom_range(0, 255));
      capture_frame(1'b1, new_led);
      checks++; if (x_val !== 11'(model_pos(resp[0], resp[1]))) begin fails++; $display("[TB] FAIL rand%0d_x: got %0d, expected %0d", i, x_val, model_pos(resp[0], resp[1])); end
      checks++; if (y_val !== 11'(model_pos(resp[2], resp[3]))) begin fails++; $display("[TB] FAIL rand%0d_y: got %0d, expected %0d", i, y_val, model_pos(resp[2], resp[3])); end
      checks++; if (int'(btn) != int'(resp[4]) % 8) begin fails++; $display("[TB] FAIL rand%0d_btn: got %0d, expected %0d", i, btn, int'(resp[4]) % 8); end
      checks++; if (int'(seen_mosi[0]) != 128 + int'(led_start)) begin fails++; $display("[TB] FAIL rand%0d_cmd: got %h, expected %h", i, seen_mosi[0], 128 + int'(led_start)); end
      checks++; if (f_valid_pulses != 1) begin fails++; $display("[TB] FAIL rand%0d_valid: got %0d, expected 1", i, f_valid_pulses); end
      checks++; if (f_fall_cyc - f_prev_fall != POLL_CYC) begin fails++; $display("[TB] FAIL rand%0d_period: got %0d, expected %0d", i, f_fall_cyc - f_prev_fall, POLL_CYC); end
      led_start = new_led;
    end
  endtask

  task automatic test_back_to_back();
    resp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    capture_frame(1'b0, 2'b00);
    checks++; if (x_val !== 11'd0 || y_val !== 11'd0 || btn !== 3'd0) begin fails++; $display("[TB] FAIL b2b_zero: got %0d/%0d/%0d, expected 0/0/0", x_val, y_val, btn); end
    resp = '{8'hFF, 8'h03, 8'hFF, 8'h03, 8'h07};
    capture_frame(1'b0, 2'b00);
    checks++; if (f_hold_bad != 0) begin fails++; $display("[TB] FAIL b2b_hold: got %0d early changes, expected 0", f_hold_bad); end
    checks++; if (x_val !== 11'd1023 || y_val !== 11'd1023 || btn !== 3'd7) begin fails++; $display("[TB] FAIL b2b_full: got %0d/%0d/%0d, expected 1023/1023/7", x_val, y_val, btn); end
    checks++; if (f_fall_cyc - f_prev_fall != POLL_CYC) begin fails++; $display("[TB] FAIL b2b_period: got %0d, expected %0d", f_fall_cyc - f_prev_fall, POLL_CYC); end
    checks++; if (mosi_bad != 0) begin fails++; $display("[TB] FAIL b2b_mosi_stable: got %0d violations, expected 0", mosi_bad); end
  endtask

  initial begin
    test_reset();
    test_spec_frame();
    test_reset_mid_frame();
    test_random_frames();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
